ppu_video_timing: RTL and testbench

//  Parametrised raster timing generator for the PPU. Replaces the fixed 320x240 counter.

---
 rtl/ppu_timing_pkg.sv | 36 +++
 rtl/ppu_video_timing_if.sv | 28 ++
 rtl/ppu_axis_counter.sv | 57 +++++
 rtl/ppu_video_timing.sv | 107 ++++++++++
 tb/tb_ppu_video_timing.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ppu_timing_pkg.sv
// Shared types and elaboration-time helpers for the PPU raster timing generator.
package ppu_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    // Ceiling log2, never less than 1 so that it is usable directly as a width.
    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/ppu_video_timing_if.sv
// Video timing bundle between the raster generator and the vram/scanout path.
interface ppu_video_timing_if #(
    parameter int X_W    = 9,
    parameter int Y_W    = 9,
    parameter int ADDR_W = 17
);
    logic              pix_ce;
    logic              hblank;
    logic              vblank;
    logic              hsync;
    logic              vsync;
    logic              de;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] fb_addr;
    logic              line_start;
    logic              frame_start;

    modport master (
        input  pix_ce,
        output hblank, vblank, hsync, vsync, de, x, y, fb_addr, line_start, frame_start
    );

    modport slave (
        output pix_ce,
        input  hblank, vblank, hsync, vsync, de, x, y, fb_addr, line_start, frame_start
    );
endinterface

// File: rtl/ppu_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
module ppu_axis_counter
    import ppu_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = 320,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 32,
    parameter int unsigned BP     = 32,
    parameter int          CW     = clog2(axis_total(ACTIVE, FP, SYNC, BP))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [CW-1:0] count,
    output phase_e        phase,
    output logic          wrap
);

    phase_e        phase_q, phase_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] plen_q, plen_d;

    // Combinational: true on the last position of the axis, used by the next level up.
    assign wrap  = (phase_q == PH_BACK) && (plen_q == CW'(BP - 1));
    assign count = count_q;
    assign phase = phase_q;

    always_comb begin
        phase_d = phase_q;
        plen_d  = plen_q;
        count_d = count_q;
        if (step) begin
            count_d = wrap ? '0 : count_q + CW'(1);
            plen_d  = plen_q + CW'(1);
            case (phase_q)
                PH_ACTIVE: if (plen_q == CW'(ACTIVE - 1)) begin phase_d = PH_FRONT;  plen_d = '0; end
                PH_FRONT:  if (plen_q == CW'(FP - 1))     begin phase_d = PH_SYNC;   plen_d = '0; end
                PH_SYNC:   if (plen_q == CW'(SYNC - 1))   begin phase_d = PH_BACK;   plen_d = '0; end
                PH_BACK:   if (plen_q == CW'(BP - 1))     begin phase_d = PH_ACTIVE; plen_d = '0; end
                default:                                  begin phase_d = PH_ACTIVE; plen_d = '0; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_ACTIVE;
            plen_q  <= '0;
            count_q <= '0;
        end else begin
            phase_q <= phase_d;
            plen_q  <= plen_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ppu_video_timing.sv
// Parametrised raster timing generator: porches, sync, pixel enable, SCALE replication
// and an incrementally built linear framebuffer read address.
module ppu_video_timing
    import ppu_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 32,
    parameter int unsigned H_BP     = 32,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 15,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned SCALE    = 1,
    parameter int          ADDR_W   = 17
) (
    input logic               clk,
    input logic               rst,
    ppu_video_timing_if.master vid
);

    localparam int XW = clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int YW = clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam int SW = (SCALE > 1) ? clog2(SCALE) : 1;
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE / SCALE);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    phase_e        h_phase, v_phase;
    logic          h_wrap, v_wrap;
    logic          x_sub_last, y_sub_last;

    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic              line_start_q, line_start_d;
    logic              frame_start_q, frame_start_d;

    ppu_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(XW)
    ) u_h (
        .clk(clk), .rst(rst), .step(vid.pix_ce),
        .count(x), .phase(h_phase), .wrap(h_wrap)
    );

    ppu_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(YW)
    ) u_v (
        .clk(clk), .rst(rst), .step(h_wrap & vid.pix_ce),
        .count(y), .phase(v_phase), .wrap(v_wrap)
    );

    // Last replicated column/row of a source pixel; SCALE is a power of two.
    assign x_sub_last = (SCALE == 1) ? 1'b1 : (x[SW-1:0] == SW'(SCALE - 1));
    assign y_sub_last = (SCALE == 1) ? 1'b1 : (y[SW-1:0] == SW'(SCALE - 1));

    always_comb begin
        fb_addr_d     = fb_addr_q;
        line_base_d   = line_base_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (vid.pix_ce) begin
            if (h_wrap) begin
                line_start_d = 1'b1;
                if (v_wrap) begin
                    frame_start_d = 1'b1;
                    line_base_d   = '0;
                    fb_addr_d     = '0;
                end else if (!y_sub_last) begin
                    fb_addr_d = line_base_q;
                end else begin
                    line_base_d = line_base_q + LINE_STEP;
                    fb_addr_d   = line_base_q + LINE_STEP;
                end
            end else if (h_phase == PH_ACTIVE && x_sub_last) begin
                fb_addr_d = fb_addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_addr_q     <= '0;
            line_base_q   <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            fb_addr_q     <= fb_addr_d;
            line_base_q   <= line_base_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // All outputs decode the same registered (x,y) state, so they stay mutually aligned.
    assign vid.x           = x;
    assign vid.y           = y;
    assign vid.hblank      = (h_phase != PH_ACTIVE);
    assign vid.vblank      = (v_phase != PH_ACTIVE);
    assign vid.de          = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    assign vid.hsync       = (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign vid.vsync       = (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign vid.fb_addr     = fb_addr_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_ppu_video_timing.sv
// Bench for ppu_video_timing on a 14x7 raster, SCALE=1 and SCALE=2 instances in lockstep.
module tb_ppu_video_timing;
    import ppu_timing_pkg::*;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int XW = clog2(HT);
    localparam int YW = clog2(VT);
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;
    logic ce;
    always #5 clk = ~clk;

    ppu_video_timing_if #(.X_W(XW), .Y_W(YW), .ADDR_W(AW)) v1 ();
    ppu_video_timing_if #(.X_W(XW), .Y_W(YW), .ADDR_W(AW)) v2 ();
    assign v1.pix_ce = ce;
    assign v2.pix_ce = ce;

    ppu_video_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .SCALE(1), .ADDR_W(AW)
    ) dut1 (.clk(clk), .rst(rst), .vid(v1));

    ppu_video_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .SCALE(2), .ADDR_W(AW)
    ) dut2 (.clk(clk), .rst(rst), .vid(v2));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference raster position and pulses, advanced by counting pixel enables.
    int mx, my, nx, ny;
    bit mls, mfs;
    bit started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mx <= 0; my <= 0; mls <= 1'b0; mfs <= 1'b0; started <= 1'b1;
        end else if (ce) begin
            nx = (mx + 1) % HT;
            ny = (nx == 0) ? (my + 1) % VT : my;
            mx  <= nx;
            my  <= ny;
            mls <= (nx == 0);
            mfs <= (nx == 0) && (ny == 0);
        end else begin
            mls <= 1'b0;
            mfs <= 1'b0;
        end
    end

    int de_cnt, fs_cnt, seq;
    bit seq_en = 1'b0;

    always @(negedge clk) begin
        if (started) begin
            chk("x",           int'(v1.x),           mx);
            chk("y",           int'(v1.y),           my);
            chk("hblank",      int'(v1.hblank),      int'(mx >= HA));
            chk("vblank",      int'(v1.vblank),      int'(my >= VA));
            chk("hsync",       int'(v1.hsync),       int'(!(mx >= HA + HF && mx < HA + HF + HS)));
            chk("vsync",       int'(v1.vsync),       int'(!(my >= VA + VF && my < VA + VF + VS)));
            chk("de",          int'(v1.de),          int'(mx < HA && my < VA));
            chk("line_start",  int'(v1.line_start),  int'(mls));
            chk("frame_start", int'(v1.frame_start), int'(mfs));
            chk("x_s2",        int'(v2.x),           mx);
            chk("de_s2",       int'(v2.de),          int'(mx < HA && my < VA));
            if (mx < HA && my < VA) begin
                chk("fb_addr",    int'(v1.fb_addr), my * HA + mx);
                chk("fb_addr_s2", int'(v2.fb_addr), (my / 2) * (HA / 2) + mx / 2);
            end
            if (rst) begin
                de_cnt = 0; fs_cnt = 0; seq = 0;
            end else begin
                if (v1.de) de_cnt++;
                if (v1.frame_start) fs_cnt++;
                if (seq_en && v1.de) begin
                    if (mfs) seq = 0;
                    chk("fb_seq", int'(v1.fb_addr), seq);
                    seq++;
                end
            end
        end
    end

    task automatic ce_steps(input int n);
        ce = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ce  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_x",      int'(v1.x), 0);
        chk("rst_y",      int'(v1.y), 0);
        chk("rst_fb",     int'(v1.fb_addr), 0);
        chk("rst_de",     int'(v1.de), 1);
        chk("rst_hblank", int'(v1.hblank), 0);
        chk("rst_vblank", int'(v1.vblank), 0);
        chk("rst_hsync",  int'(v1.hsync), 1);
        chk("rst_vsync",  int'(v1.vsync), 1);
        chk("rst_ls",     int'(v1.line_start), 0);
        chk("rst_fs",     int'(v1.frame_start), 0);

        // Full frame with pix_ce held high.
        seq_en = 1'b1;
        ce_steps(10);
        chk("h10_x",      int'(v1.x), 10);
        chk("h10_hblank", int'(v1.hblank), 1);
        chk("h10_hsync",  int'(v1.hsync), 0);
        ce_steps(2);
        chk("h12_hsync",  int'(v1.hsync), 1);
        chk("h12_hblank", int'(v1.hblank), 1);
        chk("h12_vblank", int'(v1.vblank), 0);
        ce_steps(86);
        chk("f98_fs",     int'(v1.frame_start), 1);
        chk("f98_ls",     int'(v1.line_start), 1);
        chk("f98_x",      int'(v1.x), 0);
        chk("f98_y",      int'(v1.y), 0);
        chk("f98_fb",     int'(v1.fb_addr), 0);
        chk("f98_de_cnt", de_cnt, 32);
        chk("f98_fs_cnt", fs_cnt, 0);
        ce_steps(1);
        chk("f99_fs",     int'(v1.frame_start), 0);
        chk("f99_fs_cnt", fs_cnt, 1);
        seq_en = 1'b0;

        // Vertical sync line.
        do_reset();
        ce_steps(5 * HT + 3);
        chk("y5_y",      int'(v1.y), 5);
        chk("y5_vsync",  int'(v1.vsync), 0);
        chk("y5_vblank", int'(v1.vblank), 1);
        chk("y5_de",     int'(v1.de), 0);

        // SCALE=2 address generation.
        do_reset();
        ce_steps(2 * HT + 2);
        chk("s2_x2y2_fb", int'(v2.fb_addr), 5);
        ce_steps(HT + 5);
        chk("s2_x7y3_x",  int'(v2.x), 7);
        chk("s2_x7y3_fb", int'(v2.fb_addr), 7);

        // pix_ce toggling every cycle.
        do_reset();
        for (int i = 0; i < HT * VT; i++) begin
            ce = 1'b1;
            @(posedge clk);
            #1;
            if (i == HT * VT - 1) begin
                chk("tog_fs", int'(v1.frame_start), 1);
                chk("tog_ls", int'(v1.line_start), 1);
            end
            ce = 1'b0;
            @(posedge clk);
            #1;
            if (i == HT * VT - 1) begin
                chk("tog_fs_low", int'(v1.frame_start), 0);
                chk("tog_ls_low", int'(v1.line_start), 0);
                chk("tog_x_hold", int'(v1.x), 0);
            end
        end
        chk("tog_fs_cnt", fs_cnt, 1);

        // Reset in the middle of a frame.
        do_reset();
        ce_steps(2 * HT + 5);
        chk("mid_x", int'(v1.x), 5);
        chk("mid_y", int'(v1.y), 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_x",  int'(v1.x), 0);
        chk("mid_rst_y",  int'(v1.y), 0);
        chk("mid_rst_fb", int'(v1.fb_addr), 0);
        chk("mid_rst_fs", int'(v1.frame_start), 0);
        ce_steps(HT * VT - 1);
        chk("mid_97_fs",  int'(v1.frame_start), 0);
        chk("mid_97_cnt", fs_cnt, 0);
        ce_steps(1);
        chk("mid_98_fs",  int'(v1.frame_start), 1);

        ce = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
